// File: rtl/dt_pkg.sv
// Shared constants and loader state encoding for the distance-transform datapath.
// The DT core and the bench use the same definitions.
package dt_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int STI_AW = 10;
    localparam int RES_AW = 14;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_PRIME  = 2'd1,
        LD_STREAM = 2'd2,
        LD_FIN    = 2'd3
    } ld_state_t;

endpackage

// File: rtl/sti_unpack_sr.sv
// 16-bit load/shift register that turns a packed ROM word into a serial pixel stream.
// The MSB is the leftmost pixel of the word.
module sti_unpack_sr (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        shift,
    input  logic [15:0] din,
    output logic        msb
);

    logic [15:0] sr;

    // Load wins over shift so the word boundary reload happens without a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[14:0], 1'b0};
        end
    end

    assign msb = sr[15];

endmodule

// File: rtl/sti_loader.sv
// Unpacks the 1024x16 binary source image into one byte per pixel in the result RAM,
// one pixel per clock, and reports completion plus the number of object pixels.
module sti_loader
    import dt_pkg::*;
#(
    parameter logic [PIX_W-1:0] FG_VAL       = 8'h01,
    parameter bit               FORCE_BORDER = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                sti_rd,
    output logic [STI_AW-1:0]   sti_addr,
    input  logic [15:0]         sti_di,
    output logic                res_wr,
    output logic [RES_AW-1:0]   res_addr,
    output logic [PIX_W-1:0]    res_do,
    output logic [RES_AW:0]     fg_count,
    output ld_state_t           dbg_state
);

    localparam logic [RES_AW-1:0] LAST_PIX = RES_AW'(IMG_W * IMG_H - 1);
    localparam int                COL_W    = RES_AW / 2;

    ld_state_t            state, state_nxt;
    logic [RES_AW-1:0]    pix;
    logic [STI_AW-1:0]    word;
    logic [COL_W-1:0]     row, col;
    logic                 word_end, last_word, on_border, fg_pix;
    logic                 accept, sr_load, sr_shift, sr_msb;

    assign word      = pix[RES_AW-1:4];
    assign word_end  = &pix[3:0];
    assign last_word = &word;
    assign row       = pix[RES_AW-1:COL_W];
    assign col       = pix[COL_W-1:0];
    assign on_border = (row == '0) || (&row) || (col == '0) || (&col);
    assign fg_pix    = sr_msb && !(FORCE_BORDER && on_border);

    sti_unpack_sr u_sr (
        .clk   (clk),
        .reset (reset),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sti_di),
        .msb   (sr_msb)
    );

    // Handshake: start is a one-cycle request sampled only in LD_IDLE; busy covers
    // PRIME/STREAM/FIN and done is a level that stays up until the next accepted start.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sti_rd    = 1'b0;
        sti_addr  = '0;
        res_wr    = 1'b0;
        case (state)
            LD_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = LD_PRIME;
                end
            end
            LD_PRIME: begin
                sti_rd    = 1'b1;
                sr_load   = 1'b1;
                state_nxt = LD_STREAM;
            end
            LD_STREAM: begin
                res_wr = 1'b1;
                // Fetch the next word during the last pixel of the current one.
                if (word_end && !last_word) begin
                    sti_rd   = 1'b1;
                    sti_addr = word + STI_AW'(1);
                    sr_load  = 1'b1;
                end else begin
                    sr_shift = 1'b1;
                end
                if (pix == LAST_PIX) begin
                    state_nxt = LD_FIN;
                end
            end
            LD_FIN: begin
                state_nxt = LD_IDLE;
            end
            default: begin
                state_nxt = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LD_IDLE;
            pix      <= '0;
            fg_count <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pix      <= '0;
                fg_count <= '0;
                done     <= 1'b0;
            end else if (state == LD_STREAM) begin
                // pix wraps to 0 after the last pixel, leaving res_addr at 0 when idle.
                pix <= pix + RES_AW'(1);
                if (fg_pix) begin
                    fg_count <= fg_count + (RES_AW + 1)'(1);
                end
            end
            if (state == LD_FIN) begin
                done <= 1'b1;
            end
        end
    end

    assign busy      = (state != LD_IDLE);
    assign res_addr  = pix;
    assign res_do    = (res_wr && fg_pix) ? FG_VAL : '0;
    assign dbg_state = state;

endmodule

// File: doc/sti_loader.md
# sti_loader

Front-end stage of the distance-transform datapath. It reads the packed binary source image from the stimulus ROM (1024 × 16-bit words, one 128×128 bitmap) and unpacks it into the result RAM as one byte per pixel. Each pixel is written as 8'h00 for background or FG_VAL for object, which is exactly the initial map the forward pass expects. It runs at one pixel per clock with no bubbles between words. It reports completion and the object-pixel count to the DT controller.

## Interface
- FG_VAL, 8'h01: byte written for a foreground pixel.
- FORCE_BORDER, 0: when 1, rows 0/127 and columns 0/127 are written as 8'h00 regardless of source bit.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to begin a load; ignored while busy.
- busy  out  1  high from the cycle after accepted start through the last pixel write.
- done  out  1  level; set after last write, cleared by next accepted start or reset.
- sti_rd  out  1  ROM read enable; ROM captures sti_M[sti_addr] on the falling edge of the same cycle.
- sti_addr  out  10  ROM word address.
- sti_di  in  16  ROM data; stable from the falling edge after a read until the next read.
- res_wr  out  1  RAM write enable; RAM writes on rising edge.
- res_addr  out  14  RAM pixel address = row*128 + col.
- res_do  out  8  RAM write data.
- fg_count  out  15  number of FG_VAL bytes written in the current/last load (0..16384).

## Operation
- States: IDLE → PRIME → STREAM → FIN → IDLE.
- IDLE: all strobes low. On start, clear fg_count and pixel counter, set busy, go to PRIME.
- PRIME (1 cycle): sti_rd=1, sti_addr=0. The next edge loads sti_di into the 16-bit shift register and goes to STREAM.
- STREAM (16384 cycles): res_wr=1, res_addr=pix, res_do=FG_VAL if shreg[15] else 8'h00.
  - shreg shifts left by one each cycle; MSB is the leftmost pixel, so word k bit 15 maps to pixel 16k.
  - When pix[3:0]==15 and word<1023, assert sti_rd with sti_addr=word+1. At the ending edge, load shreg from sti_di instead of shifting. No bubble.
  - FORCE_BORDER: the border test uses pix[13:7] and pix[6:0] ∈ {0,127}. Forced pixels write 8'h00 and are not counted.
- fg_count increments by 1 on every STREAM cycle whose res_do==FG_VAL. Its width holds 16384 without wrap.
- After pix==16383 is written: go to FIN. FIN lasts 1 cycle with res_wr=0, then busy←0, done←1, return to IDLE.
- start while busy: ignored, with no effect on state or counters. start while done (IDLE): accepted, done cleared on the same edge.
- reset mid-load: immediate return to IDLE, all outputs 0. RAM keeps its partial content; no cleanup is performed.

## Timing
- Reset values: busy=0, done=0, sti_rd=0, sti_addr=0, res_wr=0, res_addr=0, res_do=0, fg_count=0.
- All outputs are registered or decoded from registers only; there is no combinational path from sti_di to any output.
- Accepted start at edge T0:
  - PRIME in cycle T0–T1.
  - First write (pixel 0) occurs at edge T2.
  - Last write (pixel 16383) occurs at edge T16385.
  - done rises at edge T16386. Total 16386 cycles.
- sti_rd is high for exactly 1024 cycles per load, once per word, in ascending address order.
- res_addr increments by exactly 1 per write cycle; it never repeats or skips.

## Structure
- Shared package dt_pkg holds:
  - IMG_W=128, IMG_H=128, STI_AW=10, RES_AW=14, PIX_W=8.
  - The loader state enum.
  - These are shared with the DT core and the bench.
- One sub-module: sti_unpack_sr, a 16-bit load/shift register with MSB output. The FSM, counters and border logic stay in sti_loader.

## Test plan
- All-zero ROM: start → 16384 writes of 8'h00, fg_count=0, done at start+16386 cycles.
- All-ones ROM, FORCE_BORDER=0 → every RAM byte 8'h01, fg_count=16384. With FORCE_BORDER=1 → border 508 bytes 00, interior 01, fg_count=15876.
- ROM word k = 16'h8001 → RAM[16k]=01, RAM[16k+15]=01, others 00, fg_count=2048. Also check sti_rd pulses exactly 1024 times, with no res_wr gap at word boundaries.
- Geometry and ICC17 stimulus images → RAM equals bit-expanded image; cross-check against a bench model.
- start pulsed at cycles 100 and 5000 of a load → second pulse ignored; single done at expected cycle.
- reset asserted at write 7000 → all outputs 0 within the same cycle. A new start then performs a full reload, and fg_count matches a clean run.
